imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Serial program loader: receives a length-prefixed byte stream, assembles 32-bit words
// and writes them to instruction memory, holding the CPU in reset until a load completes.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] asm_q, asm_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wd_q, mem_wd_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        take;
    logic [15:0] new_len;

    assign byte_ready = (state_q == LEN0) || (state_q == LEN1) || (state_q == DATA);
    assign take       = byte_valid && byte_ready;
    assign new_len    = {byte_in, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = LEN0;
            end
            LEN0: begin
                if (take) begin
                    len_d[7:0] = byte_in;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (take) begin
                    len_d[15:8] = byte_in;
                    if ({1'b0, new_len} > MAX_N) begin
                        state_d = ERR;
                    end else if (new_len == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 16'd0;
                        bidx_d  = 2'd0;
                    end
                end
            end
            DATA: begin
                if (take) begin
                    asm_d[{bidx_q, 3'b000} +: 8] = byte_in;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_d == len_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they decode.
    always_comb begin
        mem_we_d   = (state_d == WRITE);
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        if (state_d == WRITE) begin
            mem_addr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
            mem_wd_d   = asm_d;
        end
        cpu_rst_d = (state_d != DONE);
        busy_d    = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA) || (state_d == WRITE);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= 16'd0;
            idx_q      <= 16'd0;
            bidx_q     <= 2'd0;
            asm_q      <= 32'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_wd_q   <= 32'd0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            bidx_q     <= bidx_d;
            asm_q      <= asm_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign cpu_rst  = cpu_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
